// File: rtl/cp0_timer_intc.sv
// CP0 timer/interrupt unit: prescaled COUNT, NUM_TIMERS sticky COMPARE channels, SW/EXT lines,
// priority encode and req/ack/eret delivery. Define CP0_INTC_SYNC_EN to double-flop ext_int.
module cp0_timer_intc #(
  parameter int NUM_TIMERS = 2,
  parameter int NUM_EXT    = 6,
  parameter int NUM_SW     = 2,
  parameter int CNT_W      = 32,
  parameter int DIV        = 2,
  localparam int IP_W      = NUM_SW + NUM_EXT + NUM_TIMERS,
  localparam int CODE_W    = (IP_W > 1) ? $clog2(IP_W) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [2:0]        wa,
  input  logic [CNT_W-1:0]  wd,
  input  logic [2:0]        ra,
  output logic [CNT_W-1:0]  rd,
  input  logic [NUM_EXT-1:0] ext_int,
  output logic              int_req,
  output logic [CODE_W-1:0] int_code,
  input  logic              int_ack,
  input  logic              eret,
  output logic [IP_W-1:0]   pending,
  output logic [1:0]        dbg_state_o
);

  localparam int PS_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TMR_LO = NUM_SW + NUM_EXT;
  localparam int SW_W   = (NUM_SW > 0) ? NUM_SW : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2} state_t;

  logic [CNT_W-1:0]      count_q;
  logic [PS_W-1:0]       ps_q;
  logic [CNT_W-1:0]      cmp_q [NUM_TIMERS];
  logic [NUM_TIMERS-1:0] tpend_q;
  logic [SW_W-1:0]       sw_q;
  logic                  ie_q;
  logic [IP_W-1:0]       im_q;
  state_t                state_q;
  logic                  int_req_q;
  logic [CODE_W-1:0]     int_code_q;

  logic [NUM_EXT-1:0]    ext_lvl;
  logic [IP_W-1:0]       pending_w;
  logic [IP_W-1:0]       eligible;
  logic [CODE_W-1:0]     win_code;
  logic                  tick;
  logic                  wr_count, wr_status, wr_cause;

  assign tick      = (ps_q == PS_W'(DIV - 1));
  assign wr_count  = we && (wa == 3'd0);
  assign wr_status = we && (wa == 3'd1);
  assign wr_cause  = we && (wa == 3'd2);

`ifdef CP0_INTC_SYNC_EN
  logic [NUM_EXT-1:0] ext_s1_q, ext_s2_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ext_s1_q <= '0;
      ext_s2_q <= '0;
    end else begin
      ext_s1_q <= ext_int;
      ext_s2_q <= ext_s1_q;
    end
  end
  assign ext_lvl = ext_s2_q;
`else
  assign ext_lvl = ext_int;
`endif

  // A COUNT write restarts the prescaler so the next increment is a full DIV away.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      ps_q    <= '0;
    end else if (wr_count) begin
      count_q <= wd;
      ps_q    <= '0;
    end else if (tick) begin
      count_q <= count_q + CNT_W'(1);
      ps_q    <= '0;
    end else begin
      ps_q    <= ps_q + PS_W'(1);
    end
  end

  // Writing COMPARE[i] clears its pending bit even when a match occurs that same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_TIMERS; i++) cmp_q[i] <= '1;
      tpend_q <= '0;
    end else begin
      for (int i = 0; i < NUM_TIMERS; i++) begin
        if (we && (wa == 3'(4 + i))) begin
          cmp_q[i]   <= wd;
          tpend_q[i] <= 1'b0;
        end else if (count_q == cmp_q[i]) begin
          tpend_q[i] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_q <= '0;
      ie_q <= 1'b0;
      im_q <= '0;
    end else begin
      if (wr_cause) begin
        for (int i = 0; i < NUM_SW; i++) sw_q[i] <= wd[8 + i];
      end
      if (wr_status) begin
        ie_q <= wd[0];
        im_q <= wd[IP_W+7:8];
      end
    end
  end

  always_comb begin
    pending_w = '0;
    for (int i = 0; i < NUM_SW; i++) pending_w[i] = sw_q[i];
    pending_w[NUM_SW +: NUM_EXT]    = ext_lvl;
    pending_w[TMR_LO +: NUM_TIMERS] = tpend_q;
  end

  assign eligible = ie_q ? (pending_w & im_q) : '0;

  // Later (higher) indices overwrite earlier ones, so the highest set bit wins.
  always_comb begin
    win_code = '0;
    for (int i = 0; i < IP_W; i++) begin
      if (eligible[i]) win_code = CODE_W'(i);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      int_req_q  <= 1'b0;
      int_code_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|eligible) begin
            state_q    <= REQ;
            int_req_q  <= 1'b1;
            int_code_q <= win_code;
          end
        end
        REQ: begin
          if (int_ack) begin
            state_q   <= SERVICE;
            int_req_q <= 1'b0;
          end else if (~|eligible) begin
            state_q   <= IDLE;
            int_req_q <= 1'b0;
          end
        end
        SERVICE: begin
          if (eret) state_q <= IDLE;
        end
        default: begin
          state_q   <= IDLE;
          int_req_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    rd = '0;
    case (ra)
      3'd0: rd = count_q;
      3'd1: begin
        rd[0]         = ie_q;
        rd[IP_W+7:8]  = im_q;
      end
      3'd2: rd[IP_W+7:8] = pending_w;
      default: begin
        for (int i = 0; i < NUM_TIMERS; i++) begin
          if (ra == 3'(4 + i)) rd = cmp_q[i];
        end
      end
    endcase
  end

  assign int_req     = int_req_q;
  assign int_code    = int_code_q;
  assign pending     = pending_w;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cp0_timer_intc.sv
// Directed bench for cp0_timer_intc: register table plus hand-written timer/interrupt sequences.
module tb_cp0_timer_intc;

`ifdef CP0_INTC_SYNC_EN
  localparam int EXT_LAT = 3;
`else
  localparam int EXT_LAT = 1;
`endif

  logic        clk, reset;
  logic        we;
  logic [2:0]  wa, ra;
  logic [31:0] wd;
  logic [5:0]  ext_int;
  logic        int_ack, eret;

  logic [31:0] rd0, rd1;
  logic        int_req0, int_req1;
  logic [3:0]  int_code0, int_code1;
  logic [9:0]  pend0, pend1;
  logic [1:0]  st0, st1;

  int n_cmp = 0;
  int n_bad = 0;

  cp0_timer_intc #(.DIV(2)) u_dut (
    .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd0),
    .ext_int(ext_int), .int_req(int_req0), .int_code(int_code0), .int_ack(int_ack),
    .eret(eret), .pending(pend0), .dbg_state_o(st0)
  );

  cp0_timer_intc #(.DIV(1)) u_dut1 (
    .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd1),
    .ext_int(ext_int), .int_req(int_req1), .int_code(int_code1), .int_ack(int_ack),
    .eret(eret), .pending(pend1), .dbg_state_o(st1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    we = 1'b1;
    wa = a;
    wd = d;
    @(negedge clk);
    we = 1'b0;
    #1;
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  wa;
    logic [31:0] wd;
    logic [2:0]  ra;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[17];
  logic found;

  initial begin
    // rd is checked before the same vector's write lands
    vecs[0]  = '{1'b1, 3'd1, 32'hFFFF_FFFF, 3'd1, 32'h0000_0000};
    vecs[1]  = '{1'b0, 3'd0, 32'h0,         3'd1, 32'h0003_FF01};
    vecs[2]  = '{1'b1, 3'd1, 32'h0,         3'd1, 32'h0003_FF01};
    vecs[3]  = '{1'b1, 3'd4, 32'h0000_1234, 3'd1, 32'h0000_0000};
    vecs[4]  = '{1'b1, 3'd5, 32'hCAFE_0000, 3'd4, 32'h0000_1234};
    vecs[5]  = '{1'b1, 3'd3, 32'hDEAD_BEEF, 3'd5, 32'hCAFE_0000};
    vecs[6]  = '{1'b1, 3'd6, 32'h0000_0055, 3'd3, 32'h0000_0000};
    vecs[7]  = '{1'b1, 3'd2, 32'hFFFF_FFFF, 3'd6, 32'h0000_0000};
    vecs[8]  = '{1'b0, 3'd0, 32'h0,         3'd2, 32'h0000_0300};
    vecs[9]  = '{1'b1, 3'd2, 32'h0000_0100, 3'd7, 32'h0000_0000};
    vecs[10] = '{1'b0, 3'd0, 32'h0,         3'd2, 32'h0000_0100};
    vecs[11] = '{1'b1, 3'd2, 32'h0,         3'd2, 32'h0000_0100};
    vecs[12] = '{1'b0, 3'd0, 32'h0,         3'd2, 32'h0000_0000};
    vecs[13] = '{1'b1, 3'd0, 32'h0000_0100, 3'd4, 32'h0000_1234};
    vecs[14] = '{1'b0, 3'd0, 32'h0,         3'd0, 32'h0000_0100};
    vecs[15] = '{1'b0, 3'd0, 32'h0,         3'd0, 32'h0000_0100};
    vecs[16] = '{1'b0, 3'd0, 32'h0,         3'd0, 32'h0000_0101};

    reset = 1'b0; we = 1'b0; wa = '0; wd = '0; ra = '0;
    ext_int = '0; int_ack = 1'b0; eret = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;

    // reset release
    repeat (10) tick();
    ra = 3'd0; #1;
    chk("count_after_10", rd0, 32'd5);
    chk("count_div1_after_10", rd1, 32'd10);
    ra = 3'd4; #1;
    chk("cmp0_reset", rd0, 32'hFFFF_FFFF);
    chk("int_req_reset", {31'b0, int_req0}, 32'd0);
    chk("int_code_reset", {28'b0, int_code0}, 32'd0);
    chk("state_reset", {30'b0, st0}, 32'd0);

    // register table
    for (int i = 0; i < 17; i++) begin
      we = vecs[i].we; wa = vecs[i].wa; wd = vecs[i].wd; ra = vecs[i].ra;
      #1;
      chk($sformatf("vec%0d_rd", i), rd0, vecs[i].exp_rd);
      @(negedge clk);
      #1;
    end
    we = 1'b0;

    // timer1 match and rewrite
    ra = 3'd0;
    wr(3'd0, 32'd0);
    wr(3'd5, 32'd8);
    wr(3'd1, 32'h0002_0001);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      if (pend0[9]) found = 1'b1;
    end
    chk("timer1_pend_seen", {31'b0, found}, 32'd1);
    chk("timer1_count_at_pend", rd0, 32'd8);
    chk("timer1_req_not_yet", {31'b0, int_req0}, 32'd0);
    tick();
    chk("timer1_req", {31'b0, int_req0}, 32'd1);
    chk("timer1_code", {28'b0, int_code0}, 32'd9);
    wr(3'd5, 32'h0000_1000);
    chk("timer1_pend_cleared", {31'b0, pend0[9]}, 32'd0);
    chk("timer1_req_held", {31'b0, int_req0}, 32'd1);
    tick();
    chk("timer1_req_dropped", {31'b0, int_req0}, 32'd0);
    chk("timer1_state_idle", {30'b0, st0}, 32'd0);

    // COUNT wrap and write-on-tick
    wr(3'd0, 32'hFFFF_FFFF);
    chk("div1_count_loaded", rd1, 32'hFFFF_FFFF);
    chk("div2_count_loaded", rd0, 32'hFFFF_FFFF);
    tick();
    chk("div1_count_wrap", rd1, 32'd0);
    chk("div2_count_hold", rd0, 32'hFFFF_FFFF);
    tick();
    chk("div2_count_wrap", rd0, 32'd0);
    tick();
    wr(3'd0, 32'h0000_0050);
    chk("div2_write_on_tick", rd0, 32'h50);
    chk("div1_write_on_tick", rd1, 32'h50);
    tick();
    chk("div2_after_write", rd0, 32'h50);
    chk("div1_after_write", rd1, 32'h51);

    // external lines, ack, eret
    wr(3'd1, 32'h0000_8401);
    ext_int = 6'b100001;
    #1;
    chk("ext_req_same_cycle", {31'b0, int_req0}, 32'd0);
    repeat (EXT_LAT - 1) begin
      tick();
      chk("ext_req_latency", {31'b0, int_req0}, 32'd0);
    end
    tick();
    chk("ext_req", {31'b0, int_req0}, 32'd1);
    chk("ext_code", {28'b0, int_code0}, 32'd7);
    chk("ext_pending", {22'b0, pend0}, 32'h084);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    chk("ack_drops_req", {31'b0, int_req0}, 32'd0);
    chk("ack_state_service", {30'b0, st0}, 32'd2);
    repeat (4) tick();
    chk("service_no_req", {31'b0, int_req0}, 32'd0);
    eret = 1'b1; tick(); eret = 1'b0;
    chk("eret_cycle_no_req", {31'b0, int_req0}, 32'd0);
    chk("eret_state_idle", {30'b0, st0}, 32'd0);
    tick();
    chk("post_eret_req", {31'b0, int_req0}, 32'd1);
    chk("post_eret_code", {28'b0, int_code0}, 32'd7);
    int_ack = 1'b1; eret = 1'b1; tick(); int_ack = 1'b0; eret = 1'b0;
    chk("ack_eret_state", {30'b0, st0}, 32'd2);
    repeat (2) tick();
    chk("ack_eret_no_req", {31'b0, int_req0}, 32'd0);
    ext_int = '0;
    repeat (4) tick();
    eret = 1'b1; tick(); eret = 1'b0;
    repeat (2) tick();
    chk("ext_idle_after", {30'b0, st0}, 32'd0);

    // software pending, ie cleared in REQ
    wr(3'd1, 32'h0000_0101);
    wr(3'd2, 32'h0000_0100);
    chk("sw_pending", {22'b0, pend0}, 32'h001);
    tick();
    chk("sw_req", {31'b0, int_req0}, 32'd1);
    chk("sw_code", {28'b0, int_code0}, 32'd0);
    wr(3'd1, 32'h0000_0100);
    chk("ie_clear_req_held", {31'b0, int_req0}, 32'd1);
    tick();
    chk("ie_clear_req_drop", {31'b0, int_req0}, 32'd0);
    chk("ie_clear_state", {30'b0, st0}, 32'd0);
    wr(3'd2, 32'd0);

    // COMPARE write in the match cycle
    ra = 3'd0;
    wr(3'd0, 32'h10);
    wr(3'd4, 32'h12);
    repeat (3) tick();
    chk("cmp0_count_match", rd0, 32'h12);
    chk("cmp0_pend_before", {31'b0, pend0[8]}, 32'd0);
    wr(3'd4, 32'h40);
    chk("cmp0_write_wins", {31'b0, pend0[8]}, 32'd0);
    tick();
    chk("cmp0_still_clear", {31'b0, pend0[8]}, 32'd0);

    // asynchronous reset during REQ
    wr(3'd1, 32'h0000_0401);
    ext_int = 6'b000001;
    repeat (EXT_LAT) tick();
    chk("rst_pre_req", {31'b0, int_req0}, 32'd1);
    reset = 1'b0;
    #1;
    chk("rst_async_req", {31'b0, int_req0}, 32'd0);
    chk("rst_async_count", rd0, 32'd0);
    chk("rst_async_state", {30'b0, st0}, 32'd0);
    ext_int = '0;
    tick();
    reset = 1'b1;
    tick();
    ra = 3'd4; #1;
    chk("rst_cmp0", rd0, 32'hFFFF_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
